// File: rtl/mxint_exp_sched.sv
// Round-robin scheduler sharing one mxint_exp unit between NUM_REQ requesters,
// routing results back in issue order through a tag FIFO. Row lock: MXINT_EXP_SCHED_ROW_LOCK_EN.
module mxint_exp_sched #(
  parameter int NUM_REQ            = 4,
  parameter int BLOCK_SIZE         = 16,
  parameter int DATA_IN_MAN_WIDTH  = 8,
  parameter int DATA_IN_EXP_WIDTH  = 3,
  parameter int DATA_OUT_MAN_WIDTH = 10,
  parameter int DATA_OUT_EXP_WIDTH = 4,
  parameter int TAG_DEPTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_IN_MAN_WIDTH-1:0]  req_mdata_in [NUM_REQ][BLOCK_SIZE],
  input  logic [DATA_IN_EXP_WIDTH-1:0]  req_edata_in [NUM_REQ],
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_IN_MAN_WIDTH-1:0]  exp_mdata_out [BLOCK_SIZE],
  output logic [DATA_IN_EXP_WIDTH-1:0]  exp_edata_out,
  output logic                          exp_valid,
  input  logic                          exp_ready,
  input  logic [DATA_OUT_MAN_WIDTH-1:0] exp_mdata_in [BLOCK_SIZE],
  input  logic [DATA_OUT_EXP_WIDTH-1:0] exp_edata_in [BLOCK_SIZE],
  input  logic                          exp_in_valid,
  output logic                          exp_in_ready,
  output logic [DATA_OUT_MAN_WIDTH-1:0] rsp_mdata_out [BLOCK_SIZE],
  output logic [DATA_OUT_EXP_WIDTH-1:0] rsp_edata_out [BLOCK_SIZE],
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [$clog2(TAG_DEPTH):0]    inflight,
  output logic                          err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  typedef logic [IDW-1:0] id_t;

  id_t            ptr_q, ptr_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           hold_q, hold_d;
  id_t            hold_id_q, hold_id_d;
  id_t            tag_mem_q [TAG_DEPTH];
  id_t            tag_mem_d [TAG_DEPTH];
`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
  logic           lock_q, lock_d;
  id_t            lock_id_q, lock_id_d;
`else
  logic           unused_last;
  assign unused_last = ^req_last;
`endif

  id_t  grant, head;
  logic cand_valid, full, empty, push, pop;

  // First valid requester at or after p, wrapping at NUM_REQ.
  function automatic id_t rr_pick(input id_t p, input logic [NUM_REQ-1:0] v);
    id_t pick;
    int  s;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = int'(p) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (v[id_t'(s)]) pick = id_t'(s);
    end
    return pick;
  endfunction

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = tag_mem_q[rd_q];

  // NOTE: every output of a combinational block gets a default first, otherwise
  // an uncovered path holds its old value and synthesis infers a latch.
  always_comb begin
    grant      = rr_pick(ptr_q, req_valid);
    cand_valid = |req_valid;
    // A beat stalled by exp_ready keeps its owner so arbitration cannot swap it.
    if (hold_q) begin
      grant      = hold_id_q;
      cand_valid = req_valid[hold_id_q];
    end
`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
    if (lock_q) begin
      grant      = lock_id_q;
      cand_valid = req_valid[lock_id_q];
    end
`endif
    exp_valid        = cand_valid && !full;
    req_ready        = '0;
    req_ready[grant] = exp_ready && !full;
    for (int k = 0; k < BLOCK_SIZE; k++) exp_mdata_out[k] = req_mdata_in[grant][k];
    exp_edata_out    = req_edata_in[grant];
    push             = exp_valid && exp_ready;

    rsp_valid        = '0;
    rsp_valid[head]  = exp_in_valid && !empty;
    exp_in_ready     = rsp_ready[head] && !empty;
    pop              = exp_in_valid && exp_in_ready;
  end

  assign rsp_mdata_out = exp_mdata_in;
  assign rsp_edata_out = exp_edata_in;
  assign inflight      = cnt_q;
  assign err           = err_q;

  always_comb begin
    ptr_d     = push ? ((grant == id_t'(NUM_REQ - 1)) ? '0 : grant + id_t'(1)) : ptr_q;
    hold_d    = exp_valid && !exp_ready;
    hold_id_d = grant;
    wr_d      = wr_q + PW'(push);
    rd_d      = rd_q + PW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    err_d     = err_q | (exp_in_valid && empty);
    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_q] = grant;
`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (push) begin
      lock_d    = !req_last[grant];
      lock_id_d = grant;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  // NOTE: the tag storage is not reset; an entry is only read while the
  // occupancy count says it holds a live tag.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_mxint_exp_sched.sv
// Scoreboard bench for mxint_exp_sched: directed stimulus queues expected issue and
// response owners; a monitor compares them against every DUT handshake.
module tb_mxint_exp_sched;

  localparam int NR = 4;
  localparam int BS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_mdata_in [NR][BS];
  logic [2:0] req_edata_in [NR];
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [7:0] exp_mdata_out [BS];
  logic [2:0] exp_edata_out;
  logic       exp_valid, exp_ready;
  logic [9:0] exp_mdata_in [BS];
  logic [3:0] exp_edata_in [BS];
  logic       exp_in_valid, exp_in_ready;
  logic [9:0] rsp_mdata_out [BS];
  logic [3:0] rsp_edata_out [BS];
  logic [NR-1:0] rsp_valid, rsp_ready;
  logic [3:0] inflight;
  logic       err;

  int n_checks = 0;
  int n_fails  = 0;
  int iss_q[$];
  int rsp_q[$];
  int unit_q[$];
  int serial = 1;
  bit loop_en = 1'b0;

  mxint_exp_sched dut (
    .clk(clk), .rst(rst),
    .req_mdata_in(req_mdata_in), .req_edata_in(req_edata_in),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .exp_mdata_out(exp_mdata_out), .exp_edata_out(exp_edata_out),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_mdata_in(exp_mdata_in), .exp_edata_in(exp_edata_in),
    .exp_in_valid(exp_in_valid), .exp_in_ready(exp_in_ready),
    .rsp_mdata_out(rsp_mdata_out), .rsp_edata_out(rsp_edata_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unit model: presents the oldest outstanding block, 2 time units after the edge.
  initial begin
    exp_in_valid = 1'b0;
    for (int k = 0; k < BS; k++) begin
      exp_mdata_in[k] = '0;
      exp_edata_in[k] = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      if (unit_q.size() > 0) begin
        exp_in_valid = 1'b1;
        for (int k = 0; k < BS; k++) begin
          exp_mdata_in[k] = 10'(unit_q[0] * 16 + k);
          exp_edata_in[k] = 4'(unit_q[0] + k);
        end
      end else begin
        exp_in_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations on each issue and return handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_in_valid && exp_in_ready) begin
          if (rsp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_rsp: got rsp_valid 0x%0h, expected none", rsp_valid);
          end else begin
            int id;
            bit ok;
            id = rsp_q.pop_front();
            check("rsp_owner", 32'(rsp_valid), 32'(1) << id);
            ok = 1'b1;
            for (int k = 0; k < BS; k++)
              if (rsp_mdata_out[k] !== exp_mdata_in[k] || rsp_edata_out[k] !== exp_edata_in[k]) ok = 1'b0;
            check("rsp_data", 32'(ok), 32'd1);
          end
          if (unit_q.size() > 0) void'(unit_q.pop_front());
        end
        if (exp_valid && exp_ready) begin
          if (iss_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_issue: got edata %0d, expected none", exp_edata_out);
          end else begin
            int id;
            bit ok;
            id = iss_q.pop_front();
            check("issue_id", 32'(exp_edata_out), 32'(id));
            ok = 1'b1;
            for (int k = 0; k < BS; k++)
              if (exp_mdata_out[k] !== 8'(id * 16 + k)) ok = 1'b0;
            check("issue_data", 32'(ok), 32'd1);
          end
          if (loop_en) begin
            unit_q.push_back(serial);
            serial++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
  // {valid, last} per cycle for requesters 1:0 and the expected exp_valid.
  localparam logic [4:0] ROW_TBL [9] = '{
    5'b11_00_1, 5'b10_00_0, 5'b10_00_0, 5'b11_00_1, 5'b11_01_1,
    5'b10_00_1, 5'b10_00_1, 5'b10_10_1, 5'b00_00_0
  };
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last  = '0;
    exp_ready = 1'b0;
    rsp_ready = '1;
    for (int r = 0; r < NR; r++) begin
      req_edata_in[r] = 3'(r);
      for (int k = 0; k < BS; k++) req_mdata_in[r][k] = 8'(r * 16 + k);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_exp_valid", 32'(exp_valid), 0);
    check("rst_exp_in_ready", 32'(exp_in_ready), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_err", 32'(err), 0);

    // Fairness: all requesters valid, 1-cycle loopback.
    tick();
    loop_en = 1'b1;
    exp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iss_q.push_back(i % 4);
      rsp_q.push_back(i % 4);
    end
    req_valid = '1;
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("fair_drained", 32'(inflight), 0);

    // Backpressure on requester 2.
    tick();
    exp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(exp_valid), 1);
      check("bp_edata", 32'(exp_edata_out), 2);
      check("bp_mdata5", 32'(exp_mdata_out[5]), 37);
      check("bp_req_ready", 32'(req_ready[2]), 0);
    end
    tick();
    iss_q.push_back(2);
    rsp_q.push_back(2);
    exp_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("bp_drained", 32'(inflight), 0);
    loop_en = 1'b0;

    // Full: no returns while requester 0 streams.
    tick();
    for (int i = 0; i < 9; i++) begin
      iss_q.push_back(0);
      rsp_q.push_back(0);
    end
    req_valid = 4'b0001;
    repeat (10) tick();
    @(negedge clk);
    check("full_inflight", 32'(inflight), 8);
    check("full_exp_valid", 32'(exp_valid), 0);
    check("full_req_ready", 32'(req_ready), 0);
    tick();
    unit_q.push_back(serial);
    serial++;
    @(negedge clk);
    check("full_pop_ready", 32'(exp_in_ready), 1);
    check("full_still_blocked", 32'(exp_valid), 0);
    @(negedge clk);
    check("full_resume", 32'(exp_valid), 1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("full_again", 32'(inflight), 8);
    tick();
    for (int i = 0; i < 8; i++) begin
      unit_q.push_back(serial);
      serial++;
    end
    repeat (10) tick();
    @(negedge clk);
    check("full_drained", 32'(inflight), 0);

    // Spurious return while empty.
    tick();
    unit_q.push_back(serial);
    serial++;
    @(negedge clk);
    check("spur_ready", 32'(exp_in_ready), 0);
    check("spur_rsp_valid", 32'(rsp_valid), 0);
    check("spur_err_before", 32'(err), 0);
    tick();
    unit_q.delete();
    @(negedge clk);
    check("spur_err_set", 32'(err), 1);
    repeat (3) tick();
    @(negedge clk);
    check("spur_err_sticky", 32'(err), 1);

    // Head-of-line: tags [1,3] outstanding, requester 1 stalls.
    tick();
    rsp_ready = 4'b1101;
    iss_q.push_back(1);
    iss_q.push_back(3);
    rsp_q.push_back(1);
    rsp_q.push_back(3);
    req_valid = 4'b1010;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      unit_q.push_back(serial);
      serial++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hol_ready", 32'(exp_in_ready), 0);
      check("hol_rsp_valid", 32'(rsp_valid), 32'b0010);
      check("hol_inflight", 32'(inflight), 2);
    end
    tick();
    rsp_ready = '1;
    repeat (3) tick();
    @(negedge clk);
    check("hol_drained", 32'(inflight), 0);

    // Reset mid-operation discards the outstanding tag.
    tick();
    iss_q.push_back(2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mid_inflight", 32'(inflight), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_inflight", 32'(inflight), 0);
    check("mid_rst_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    unit_q.push_back(serial);
    serial++;
    @(negedge clk);
    check("post_rst_ready", 32'(exp_in_ready), 0);
    tick();
    unit_q.delete();
    @(negedge clk);
    check("post_rst_err", 32'(err), 1);

`ifdef MXINT_EXP_SCHED_ROW_LOCK_EN
    // Row lock: 3-beat rows from 0 and 1, bubble in row 0.
    tick();
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iss_q.push_back(i / 3);
      rsp_q.push_back(i / 3);
    end
    for (int c = 0; c < 9; c++) begin
      logic [4:0] row;
      row = ROW_TBL[c];
      req_valid = {2'b00, row[4:3]};
      req_last  = {2'b00, row[2:1]};
      @(negedge clk);
      check("row_exp_valid", 32'(exp_valid), 32'(row[0]));
      tick();
    end
    req_valid = '0;
    req_last  = '0;
    repeat (3) tick();
    loop_en = 1'b0;
`endif

    repeat (3) tick();
    check("iss_q_empty", 32'(iss_q.size()), 0);
    check("rsp_q_empty", 32'(rsp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
